// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer.
// One op in flight. N shift-add or restoring-divide iterations run on operand
// magnitudes. Sign fix-up and special cases are applied as the result is loaded.
module muldiv_seq #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   fn3,
    input  logic [N-1:0] rs1_data,
    input  logic [N-1:0] rs2_data,
    output logic         stall,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] count;

    // Latched op context
    logic [2:0]    op;
    logic          neg_main;
    logic          neg_rem;
    logic          b_zero;

    // Multiply: acc = product high half, quot = multiplier shifting out / product low half.
    // Divide:   acc = partial remainder,   quot = dividend shifting out / quotient in.
    // opb holds the multiplicand or the divisor.
    logic [N-1:0]  acc;
    logic [N-1:0]  quot;
    logic [N-1:0]  opb;

    // Input-side decode
    logic          sign_a;
    logic          sign_b;
    logic          neg_a;
    logic          neg_b;
    logic [N-1:0]  mag_a;
    logic [N-1:0]  mag_b;

    // One-iteration datapath
    logic [N:0]    mul_sum;
    logic [N:0]    div_shift;
    logic [N-1:0]  div_diff;
    logic          div_ge;
    logic [N-1:0]  acc_nxt;
    logic [N-1:0]  quot_nxt;

    // Final result formation
    logic [2*N-1:0] prod;
    logic [2*N-1:0] prod_s;
    logic [N-1:0]   quo_s;
    logic [N-1:0]   rem_s;
    logic [N-1:0]   res_nxt;

    // Operand signedness and magnitudes for the op presented on the ports
    always_comb begin
        sign_a = 1'b0;
        sign_b = 1'b0;
        case (fn3)
            3'b001, 3'b100, 3'b110: begin
                sign_a = 1'b1;
                sign_b = 1'b1;
            end
            3'b010:  sign_a = 1'b1;
            default: ;
        endcase
        neg_a = sign_a & rs1_data[N-1];
        neg_b = sign_b & rs2_data[N-1];
        mag_a = neg_a ? -rs1_data : rs1_data;
        mag_b = neg_b ? -rs2_data : rs2_data;
    end

    // One shift-add or restoring-divide step on the current registers
    always_comb begin
        mul_sum   = {1'b0, acc} + (quot[0] ? {1'b0, opb} : '0);
        div_shift = {acc, quot[N-1]};
        div_ge    = div_shift >= {1'b0, opb};
        // Remainder after a successful trial is below the divisor, so N bits suffice
        div_diff  = div_shift[N-1:0] - opb;
        if (op[2]) begin
            acc_nxt  = div_ge ? div_diff : div_shift[N-1:0];
            quot_nxt = {quot[N-2:0], div_ge};
        end else begin
            acc_nxt  = mul_sum[N:1];
            quot_nxt = {mul_sum[0], quot[N-1:1]};
        end
    end

    // Sign fix-up and special-case override applied to the post-final-iteration value
    always_comb begin
        prod   = {acc_nxt, quot_nxt};
        prod_s = neg_main ? -prod : prod;
        quo_s  = neg_main ? -quot_nxt : quot_nxt;
        rem_s  = neg_rem ? -acc_nxt : acc_nxt;
        case (op)
            3'b000:                 res_nxt = prod_s[N-1:0];
            3'b001, 3'b010, 3'b011: res_nxt = prod_s[2*N-1:N];
            3'b100, 3'b101:         res_nxt = b_zero ? '1 : quo_s;
            default:                res_nxt = rem_s;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (count == CW'(N - 1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Combinational stall: released in DONE so writeback and PC advance coincide with done
    always_comb begin
        stall = ((state == S_IDLE) && start) || (state == S_RUN);
    end

    // Operand capture and iteration registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            quot     <= '0;
            opb      <= '0;
            op       <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            b_zero   <= 1'b0;
            count    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op       <= fn3;
                        neg_main <= neg_a ^ neg_b;
                        neg_rem  <= neg_a;
                        b_zero   <= (rs2_data == '0);
                        count    <= '0;
                        acc      <= '0;
                        if (fn3[2]) begin
                            quot <= mag_a;
                            opb  <= mag_b;
                        end else begin
                            quot <= mag_b;
                            opb  <= mag_a;
                        end
                    end
                end
                S_RUN: begin
                    acc   <= acc_nxt;
                    quot  <= quot_nxt;
                    count <= count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Registered status and result, timed off the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            busy <= (state_nxt != S_IDLE);
            done <= (state_nxt == S_DONE);
            if (state_nxt == S_DONE) begin
                result <= res_nxt;
            end
        end
    end

endmodule
